// File: rtl/alp_seq_pkg.sv
// alp_seq_pkg: op codes, FSM states and digit constants shared by the ALP sequential ALU (BCD ops gated by ALP_BCD_EN)
package alp_seq_pkg;
    localparam int NIBBLE_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_BIC = 4'h7;
    localparam logic [3:0] OP_PASSA = 4'h8;
    localparam logic [3:0] OP_PASSB = 4'h9;
    localparam logic [3:0] OP_DADD = 4'hA;
    localparam logic [3:0] OP_DSUB = 4'hB;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alp_seq_slice.sv
// alp_seq_slice: combinational 4-bit ALP slice; binary, logic and BCD digit ops, reserved ops yield zero
module alp_seq_slice
    import alp_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    input  logic       carry_in,
    input  logic       bcd_en,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       msb_carry_in
);
    logic [3:0] bb;
    logic [4:0] bin;
    logic [4:0] dsum;
    logic [5:0] ddif;
    logic [3:0] lo;
    assign bb = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    assign bin = {1'b0, a} + {1'b0, bb} + {4'b0, carry_in};
    assign lo = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b0, carry_in};
    assign msb_carry_in = lo[3];
    assign dsum = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
    assign ddif = {2'b0, a} - {2'b0, b} - {5'b0, carry_in};
    always_comb begin
        q = '0;
        carry_out = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                q = bin[3:0];
                carry_out = bin[4];
            end
            OP_AND:   q = a & b;
            OP_OR:    q = a | b;
            OP_XOR:   q = a ^ b;
            OP_BIC:   q = a & ~b;
            OP_PASSA: q = a;
            OP_PASSB: q = b;
            OP_DADD: begin
                carry_out = bcd_en && dsum > {1'b0, BCD_MAX};
                q = !bcd_en ? 4'd0 : carry_out ? dsum[3:0] + 4'd6 : dsum[3:0];
            end
            OP_DSUB: begin
                carry_out = bcd_en && ddif[5];
                q = !bcd_en ? 4'd0 : carry_out ? ddif[3:0] + 4'd10 : ddif[3:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alp_alu_seq.sv
// alp_alu_seq: nibble-serial multi-digit ALU with start/done handshake; DADD/DSUB exist only when ALP_BCD_EN is defined
module alp_alu_seq
    import alp_seq_pkg::*;
#(
    parameter int NIBBLES = 8,
    parameter int LEN_W = $clog2(NIBBLES) + 1,
    localparam int W = NIBBLE_W * NIBBLES
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             start_h,
    input  logic [3:0]       op_h,
    input  logic [LEN_W-1:0] len_h,
    input  logic [W-1:0]     a_h,
    input  logic [W-1:0]     b_h,
    input  logic             carry_in_h,
    output logic             ready_h,
    output logic             done_h,
    output logic [W-1:0]     result_h,
    output logic             n_h,
    output logic             z_h,
    output logic             v_h,
    output logic             c_h,
    output logic             err_h
);
`ifdef ALP_BCD_EN
    localparam logic BCD_EN = 1'b1;
`else
    localparam logic BCD_EN = 1'b0;
`endif
    state_t state, state_nx;
    logic [LEN_W-1:0] idx, len_q, len_eff;
    logic [3:0] op_q, q;
    logic [W-1:0] a_q, b_q;
    logic cy, nz, cout, mcin, last, cin_init;
    logic arith, logic_op, bcd;
    assign len_eff = (len_h == '0 || len_h > LEN_W'(NIBBLES)) ? LEN_W'(NIBBLES) : len_h;
    assign cin_init = op_h == OP_ADC ? carry_in_h : op_h == OP_SUB ? 1'b1 : op_h == OP_SBC ? ~carry_in_h : 1'b0;
    assign arith = op_q <= OP_SBC;
    assign logic_op = op_q >= OP_AND && op_q <= OP_PASSB;
    assign bcd = BCD_EN && (op_q == OP_DADD || op_q == OP_DSUB);
    assign last = idx == len_q - 1'b1;
    assign ready_h = state == IDLE;
    assign done_h = state == DONE;
    alp_seq_slice u_slice (
        .a            (a_q[NIBBLE_W-1:0]),
        .b            (b_q[NIBBLE_W-1:0]),
        .op           (op_q),
        .carry_in     (cy),
        .bcd_en       (BCD_EN),
        .q            (q),
        .carry_out    (cout),
        .msb_carry_in (mcin)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start_h ? RUN : IDLE;
            RUN:  state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state <= IDLE;
            idx <= '0;
            len_q <= '0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cy <= 1'b0;
            nz <= 1'b0;
            result_h <= '0;
            {n_h, z_h, v_h, c_h, err_h} <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_h) begin
                a_q <= a_h;
                b_q <= b_h;
                op_q <= op_h;
                len_q <= len_eff;
                cy <= cin_init;
                idx <= '0;
                nz <= 1'b0;
                result_h <= '0;
            end else if (state == RUN) begin
                // operands shift down so the slice always sees the current digit at the bottom
                result_h[idx*NIBBLE_W +: NIBBLE_W] <= q;
                a_q <= a_q >> NIBBLE_W;
                b_q <= b_q >> NIBBLE_W;
                cy <= cout;
                idx <= idx + 1'b1;
                nz <= nz | (|q);
                if (last) begin
                    n_h <= (arith | logic_op) & q[3];
                    z_h <= (arith | logic_op | bcd) & ~(nz | (|q));
                    v_h <= arith & (mcin ^ cout);
                    c_h <= arith ? (op_q[1] ? ~cout : cout) : bcd & cout;
                    err_h <= ~(arith | logic_op | bcd);
                end
            end
        end
    end
endmodule

// File: tb/tb_alp_alu_seq.sv
// tb_alp_alu_seq: directed self-checking bench for alp_alu_seq; BCD expectations follow ALP_BCD_EN
module tb_alp_alu_seq;
    logic clk_h = 1'b0;
    logic reset_h, start_h, carry_in_h;
    logic [3:0] op_h, len_h;
    logic [31:0] a_h, b_h, result_h;
    logic ready_h, done_h, n_h, z_h, v_h, c_h, err_h;
    int passed = 0;
    int total = 0;
`ifdef ALP_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif
    localparam logic [3:0] L_OP [6] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    localparam logic [31:0] L_RES [6] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'h00F0, 32'hF0F0, 32'hFF00};
    localparam logic L_N [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    alp_alu_seq dut (
        .clk_h(clk_h), .reset_h(reset_h), .start_h(start_h), .op_h(op_h), .len_h(len_h),
        .a_h(a_h), .b_h(b_h), .carry_in_h(carry_in_h), .ready_h(ready_h), .done_h(done_h),
        .result_h(result_h), .n_h(n_h), .z_h(z_h), .v_h(v_h), .c_h(c_h), .err_h(err_h)
    );

    always #5 clk_h = ~clk_h;

    wire [36:0] obs = {result_h, n_h, z_h, v_h, c_h, err_h};

    task automatic tick;
        @(posedge clk_h);
        #1;
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] len, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, output int lat);
        op_h = op; len_h = len; a_h = a; b_h = b; carry_in_h = cin; start_h = 1'b1;
        tick;
        start_h = 1'b0;
        lat = 0;
        while (!done_h && lat < 20) begin
            tick;
            lat++;
        end
        if (!done_h) begin
            total++;
            $display("FAIL timeout op=%h got no done_h within 20 cycles, exp done_h=1", op);
            lat = -1;
        end
    endtask

    task automatic test_reset;
        reset_h = 1'b1; start_h = 1'b0; op_h = '0; len_h = '0; a_h = '0; b_h = '0; carry_in_h = 1'b0;
        tick;
        tick;
        total++;
        if ({ready_h, done_h} !== 2'b10) $display("FAIL reset_hs got %b exp 10", {ready_h, done_h});
        else passed++;
        reset_h = 1'b0;
        tick;
        total++;
        if (obs !== 37'h0) $display("FAIL reset_out got %h exp 0", obs);
        else passed++;
    endtask

    task automatic test_add;
        int lat;
        run(4'h0, 4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
        total++;
        if (obs !== {32'h80000000, 5'b10100}) $display("FAIL add_ovf got %h exp %h", obs, {32'h80000000, 5'b10100});
        else passed++;
        total++;
        if (lat !== 8) $display("FAIL add_lat got %0d exp 8", lat);
        else passed++;
        tick;
        total++;
        if ({done_h, ready_h} !== 2'b01) $display("FAIL done_width got %b exp 01", {done_h, ready_h});
        else passed++;
        run(4'h1, 4'd1, 32'hF, 32'h0, 1'b1, lat);
        total++;
        if (obs !== {32'h0, 5'b01010}) $display("FAIL adc got %h exp %h", obs, {32'h0, 5'b01010});
        else passed++;
        tick;
    endtask

    task automatic test_sub;
        int lat;
        run(4'h2, 4'd8, 32'h5, 32'h7, 1'b0, lat);
        total++;
        if (obs !== {32'hFFFFFFFE, 5'b10010}) $display("FAIL sub_neg got %h exp %h", obs, {32'hFFFFFFFE, 5'b10010});
        else passed++;
        tick;
        run(4'h3, 4'd2, 32'h5, 32'h2, 1'b1, lat);
        total++;
        if (obs !== {32'h2, 5'b00000}) $display("FAIL sbc got %h exp %h", obs, {32'h2, 5'b00000});
        else passed++;
        tick;
        run(4'h2, 4'd2, 32'h80, 32'h1, 1'b0, lat);
        total++;
        if (obs !== {32'h7F, 5'b00100}) $display("FAIL sub_ovf got %h exp %h", obs, {32'h7F, 5'b00100});
        else passed++;
        tick;
    endtask

    task automatic test_bcd;
        int lat;
        logic [36:0] exp_v;
        run(4'hA, 4'd4, 32'h999, 32'h1, 1'b0, lat);
        exp_v = BCD ? {32'h1000, 5'b00000} : {32'h0, 5'b00001};
        total++;
        if (obs !== exp_v) $display("FAIL dadd_carry got %h exp %h", obs, exp_v);
        else passed++;
        total++;
        if (lat !== 4) $display("FAIL dadd_lat got %0d exp 4", lat);
        else passed++;
        tick;
        run(4'hA, 4'd8, 32'h99999999, 32'h1, 1'b0, lat);
        exp_v = BCD ? {32'h0, 5'b01010} : {32'h0, 5'b00001};
        total++;
        if (obs !== exp_v) $display("FAIL dadd_wrap got %h exp %h", obs, exp_v);
        else passed++;
        tick;
        run(4'hB, 4'd4, 32'h100, 32'h1, 1'b0, lat);
        exp_v = BCD ? {32'h99, 5'b00000} : {32'h0, 5'b00001};
        total++;
        if (obs !== exp_v) $display("FAIL dsub got %h exp %h", obs, exp_v);
        else passed++;
        tick;
        run(4'hB, 4'd2, 32'h0, 32'h1, 1'b0, lat);
        exp_v = BCD ? {32'h99, 5'b00010} : {32'h0, 5'b00001};
        total++;
        if (obs !== exp_v) $display("FAIL dsub_borrow got %h exp %h", obs, exp_v);
        else passed++;
        tick;
    endtask

    task automatic test_len;
        int lat;
        run(4'h0, 4'd9, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
        total++;
        if (obs !== {32'h0, 5'b01010}) $display("FAIL len9 got %h exp %h", obs, {32'h0, 5'b01010});
        else passed++;
        total++;
        if (lat !== 8) $display("FAIL len9_lat got %0d exp 8", lat);
        else passed++;
        tick;
    endtask

    task automatic test_logic;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run(L_OP[i], 4'd4, 32'h1234F0F0, 32'h0F0FFF00, 1'b0, lat);
            total++;
            if (obs !== {L_RES[i], L_N[i], 4'b0000})
                $display("FAIL logic_op%h got %h exp %h", L_OP[i], obs, {L_RES[i], L_N[i], 4'b0000});
            else passed++;
            tick;
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        op_h = 4'h0; len_h = 4'd8; a_h = 32'h1; b_h = 32'h1; carry_in_h = 1'b0; start_h = 1'b1;
        tick;
        start_h = 1'b0;
        tick;
        tick;
        op_h = 4'h6; a_h = 32'hFFFFFFFF; start_h = 1'b1;
        tick;
        start_h = 1'b0;
        lat = 3;
        while (!done_h && lat < 20) begin
            tick;
            lat++;
        end
        total++;
        if ({lat, obs} !== {32'd8, 32'h2, 5'b00000}) $display("FAIL ignore_start got lat=%0d %h exp lat=8 %h", lat, obs, {32'h2, 5'b00000});
        else passed++;
        tick;
        tick;
        total++;
        if ({ready_h, done_h} !== 2'b10) $display("FAIL not_queued got %b exp 10", {ready_h, done_h});
        else passed++;
    endtask

    task automatic test_reset_mid;
        int dones;
        op_h = 4'h0; len_h = 4'd8; a_h = 32'h11111111; b_h = 32'h11111111; carry_in_h = 1'b0; start_h = 1'b1;
        tick;
        start_h = 1'b0;
        tick;
        tick;
        tick;
        total++;
        if (result_h !== 32'h222) $display("FAIL mid_partial got %h exp 00000222", result_h);
        else passed++;
        reset_h = 1'b1;
        tick;
        reset_h = 1'b0;
        total++;
        if ({ready_h, done_h, result_h} !== {2'b10, 32'h0}) $display("FAIL mid_reset got %h exp %h", {ready_h, done_h, result_h}, {2'b10, 32'h0});
        else passed++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            dones += int'(done_h);
        end
        total++;
        if (dones !== 0) $display("FAIL mid_no_done got %0d done pulses exp 0", dones);
        else passed++;
    endtask

    task automatic test_reserved;
        int lat;
        logic [36:0] exp_v;
        run(4'hC, 4'd4, 32'h1234, 32'h1, 1'b0, lat);
        total++;
        if ({lat, obs} !== {32'd4, 32'h0, 5'b00001}) $display("FAIL rsv_c got lat=%0d %h exp lat=4 %h", lat, obs, {32'h0, 5'b00001});
        else passed++;
        tick;
        run(4'hF, 4'd1, 32'h0, 32'h0, 1'b0, lat);
        total++;
        if (obs !== {32'h0, 5'b00001}) $display("FAIL rsv_f got %h exp %h", obs, {32'h0, 5'b00001});
        else passed++;
        tick;
        run(4'hA, 4'd2, 32'h19, 32'h1, 1'b0, lat);
        exp_v = BCD ? {32'h20, 5'b00000} : {32'h0, 5'b00001};
        total++;
        if (obs !== exp_v) $display("FAIL rsv_a got %h exp %h", obs, exp_v);
        else passed++;
        tick;
        run(4'h0, 4'd1, 32'h1, 32'h1, 1'b0, lat);
        total++;
        if (obs !== {32'h2, 5'b00000}) $display("FAIL err_clear got %h exp %h", obs, {32'h2, 5'b00000});
        else passed++;
        tick;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_bcd;
        test_len;
        test_logic;
        test_ignore_start;
        test_reset_mid;
        test_reserved;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no end of run exp finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/alp_alu_seq.md
Name: alp_alu_seq

Overview:
Iterative multi-digit ALU built around a 4-bit ALP-style slice. It processes one nibble per clock, LSB first, and carries/borrows between nibbles through a registered carry.
Supports binary arithmetic, logic and packed-BCD add/subtract over a programmable length of 1..NIBBLES digits, so the decimal string microcode sequences need not loop in microcode.
Sits beside the existing datapath ALU in the DPM, behind a start/done handshake.

Parameters:
NIBBLES, 8, maximum operand length in 4-bit digits (≥2); data width W = 4*NIBBLES
LEN_W, $clog2(NIBBLES)+1, width of len_h

Ports:
clk_h  in  1  system clock, rising edge
reset_h  in  1  synchronous reset, active-high
start_h  in  1  request; accepted only when ready_h=1
op_h  in  4  operation code (see Behaviour)
len_h  in  LEN_W  digits to process; 0 or >NIBBLES means NIBBLES
a_h  in  W  operand A, sampled on accept
b_h  in  W  operand B, sampled on accept
carry_in_h  in  1  carry/borrow in for ADC/SBC, sampled on accept
ready_h  out  1  idle, can accept
done_h  out  1  one-cycle pulse, result/flags valid
result_h  out  W  result, held until next accept
n_h, z_h, v_h, c_h  out  1 each  condition codes, held with result_h
err_h  out  1  reserved/disabled op, held with result_h

Behaviour:
- Reset: state IDLE. ready_h=1, done_h=0, result_h=0, n/z/v/c=0, err_h=0. Takes effect in any state; an in-flight operation is discarded, with no done_h.
- Op codes: 0 ADD, 1 ADC, 2 SUB (A−B), 3 SBC (A−B−cin), 4 AND, 5 OR, 6 XOR, 7 BIC (A&~B), 8 PASSA, 9 PASSB, A DADD, B DSUB. C–F are reserved.
- FSM:
  - IDLE: on start_h, latch a, b, op, effective len L and cin. Clear the accumulator and set digit index i=0. Go to RUN.
  - RUN: compute nibble i via slice and write result[4i+3:4i]. Register the carry; i++. When i=L−1 has been processed, go to DONE.
  - DONE: done_h=1 for one cycle, flags updated; go to IDLE.
  - start_h outside IDLE is ignored (not queued).
- Latency: accept at edge t, nibble k at edge t+1+k, done_h high during cycle t+L+1. ready_h returns at t+L+2. ready_h = (state==IDLE).
- Initial carry: ADD=0; ADC=cin; SUB: internal carry 1 (A+~B+1); SBC: internal carry ~cin; DADD=0; DSUB: borrow 0.
- Binary slice: 4-bit add of A and (B or ~B) with carry.
- DADD digit: s=a+b+c; if s>9 then s+=6, cout=1. DSUB digit: d=a−b−bw; if d<0 then d+=10, bout=1. Non-BCD input digits are processed by the same formula; no error.
- Logic ops and PASS: per nibble, no carry.
- Nibbles ≥L in result_h are 0.
- Flags, computed over the processed L digits:
  - z_h = all processed nibbles zero.
  - n_h = bit 4L−1 for binary/logic/pass ops; 0 for BCD.
  - c_h = final carry for ADD/ADC/DADD. For SUB/SBC it is the final borrow (inverted carry); for DSUB it is the final borrow. 0 for logic/pass.
  - v_h = signed overflow of digit L−1 (carry into MSB xor carry out) for ADD/ADC/SUB/SBC, else 0.
- Reserved op: runs the normal L-cycle sequence. Result 0, all flags 0, err_h=1.

Optional Feature:
ALP_BCD_EN.
- Defined: DADD/DSUB behave as above.
- Undefined: ops A/B are treated as reserved (err_h=1, result 0, flags 0, same latency), and no BCD correction logic is synthesised.

Decomposition:
- Package alp_seq_pkg:
  - op code localparams;
  - state enum {IDLE, RUN, DONE};
  - NIBBLE_W=4;
  - BCD_MAX=9.
- Sub-module alp_seq_slice: purely combinational 4-bit slice.
  - Inputs: a, b (4), op, carry_in, bcd_en.
  - Outputs: q (4), carry_out, msb_carry_in (for V).
- Top holds the FSM, digit counter, operand registers and flag accumulation.

Test Plan:
1. ADD a=0x7FFFFFFF, b=1, len=0 → result 0x80000000, n=1 v=1 c=0 z=0. done_h exactly 9 cycles after accept, one cycle wide.
2. SUB a=5, b=7, len=8 → 0xFFFFFFFE, c=1 n=1 v=0. SBC a=5, b=2, cin=1, len=2 → 0x00000002, c=0.
3. DADD a=0x00000999, b=1, len=4 → 0x00001000, c=0, done at 5 cycles. DADD 0x99999999+1, len=8 → 0, c=1 z=1.
4. DSUB a=0x0100, b=1, len=4 → 0x0099, c=0. DSUB a=0, b=1, len=2 → 0x99, c=1. len=9 (>NIBBLES) behaves as 8.
5. start_h pulsed during RUN → ignored, result from the first op unchanged. reset_h during RUN digit 3 → next cycle ready_h=1, done_h never asserts, result_h=0.
6. Op=0xC → err_h=1, result 0 after L cycles. With ALP_BCD_EN undefined, op=0xA gives the same response; a following ADD clears err_h.
